// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU: funct codes, FSM states, width.
// Optional divide-by-zero shortcut is controlled by ALU_SEQ_DIVZERO_EN.
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_DIVU = 6'b011011;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DIV,
    DONE
  } state_t;

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle, WIDTH iterations.
// last pulses for one cycle once quotient/remainder are final.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;
  logic             run;
  logic [WIDTH:0]   trial;
  logic             fits;

  // quotient doubles as the dividend shift register
  assign trial = {remainder, quotient[WIDTH-1]};
  assign fits  = trial >= {1'b0, d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient  <= '0;
      remainder <= '0;
      d         <= '0;
      cnt       <= '0;
      run       <= 1'b0;
      last      <= 1'b0;
    end else begin
      last <= 1'b0;
      if (start) begin
        quotient  <= dividend;
        remainder <= '0;
        d         <= divisor;
        cnt       <= '0;
        run       <= 1'b1;
      end else if (run) begin
        quotient  <= {quotient[WIDTH-2:0], fits};
        remainder <= fits ? WIDTH'(trial - {1'b0, d})
                          : trial[WIDTH-1:0];
        if (cnt == CW'(WIDTH - 1)) begin
          cnt  <= '0;
          run  <= 1'b0;
          last <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU controller with HI/LO registers and iterative DIVU.
// Define ALU_SEQ_DIVZERO_EN for the one-cycle divide-by-zero path.
module alu_seq_ctrl #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [4:0]       shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataOut,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  import alu_pkg::*;

  state_t           state;
  logic [5:0]       op_f;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [4:0]       op_sh;
  logic [WIDTH-1:0] exec_res;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;
  logic             div_last;
  logic             accept;
  logic             is_divu;
  logic             dz_skip;
  logic             div_go;

  assign accept  = (state == IDLE) && start;
  assign is_divu = (funct == F_DIVU);

`ifdef ALU_SEQ_DIVZERO_EN
  logic dz_q;

  assign dz_skip  = (dataB == '0);
  assign div_zero = dz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dz_q <= 1'b0;
    else if (accept)
      dz_q <= is_divu && dz_skip;
  end
`else
  assign dz_skip  = 1'b0;
  assign div_zero = 1'b0;
`endif

  assign div_go = accept && is_divu && !dz_skip;

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_go),
    .dividend  (dataA),
    .divisor   (dataB),
    .quotient  (div_q),
    .remainder (div_r),
    .last      (div_last)
  );

  always_comb begin
    exec_res = '0;
    unique case (1'b1)
      (op_f == F_AND):  exec_res = op_a & op_b;
      (op_f == F_OR):   exec_res = op_a | op_b;
      (op_f == F_ADD):  exec_res = op_a + op_b;
      (op_f == F_SUB):  exec_res = op_a - op_b;
      (op_f == F_SLT):  exec_res = {{(WIDTH-1){1'b0}},
                                    $signed(op_a) < $signed(op_b)};
      (op_f == F_SLL):  exec_res = op_a << op_sh;
      (op_f == F_MFHI): exec_res = hi;
      (op_f == F_MFLO): exec_res = lo;
      default:          exec_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      dataOut <= '0;
      hi      <= '0;
      lo      <= '0;
      op_f    <= '0;
      op_a    <= '0;
      op_b    <= '0;
      op_sh   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_f  <= funct;
            op_a  <= dataA;
            op_b  <= dataB;
            op_sh <= shamt;
            busy  <= 1'b1;
            if (is_divu && dz_skip) begin
              lo      <= '1;
              hi      <= dataA;
              dataOut <= dataA;
              done    <= 1'b1;
              state   <= DONE;
            end else if (is_divu) begin
              state <= DIV;
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          dataOut <= exec_res;
          done    <= 1'b1;
          state   <= DONE;
        end
        DIV: begin
          if (div_last) begin
            lo      <= div_q;
            hi      <= div_r;
            dataOut <= div_r;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomized self-checking bench for alu_seq_ctrl (WIDTH=32).
// Honours ALU_SEQ_DIVZERO_EN for divide-by-zero expectations.
module tb_alu_seq_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [5:0]   funct;
  logic [W-1:0] dataA;
  logic [W-1:0] dataB;
  logic [4:0]   shamt;
  logic         busy;
  logic         done;
  logic [W-1:0] dataOut;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_zero;

  int n_chk = 0;
  int n_err = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

`ifdef ALU_SEQ_DIVZERO_EN
  localparam bit DZEN = 1'b1;
`else
  localparam bit DZEN = 1'b0;
`endif

  localparam logic [5:0] C_AND  = 6'h24;
  localparam logic [5:0] C_OR   = 6'h25;
  localparam logic [5:0] C_ADD  = 6'h20;
  localparam logic [5:0] C_SUB  = 6'h22;
  localparam logic [5:0] C_SLT  = 6'h2a;
  localparam logic [5:0] C_SLL  = 6'h00;
  localparam logic [5:0] C_DIVU = 6'h1b;
  localparam logic [5:0] C_MFHI = 6'h10;
  localparam logic [5:0] C_MFLO = 6'h12;

  logic [5:0] ops [10] = '{C_AND, C_OR, C_ADD, C_SUB, C_SLT,
                           C_SLL, C_DIVU, C_MFHI, C_MFLO, 6'h3f};

  always #5 clk = ~clk;

  alu_seq_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .funct    (funct),
    .dataA    (dataA),
    .dataB    (dataB),
    .shamt    (shamt),
    .busy     (busy),
    .done     (done),
    .dataOut  (dataOut),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [5:0] f,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [4:0] sh,
                        input bit spam);
    logic [W-1:0] r;
    logic [W-1:0] nhi;
    logic [W-1:0] nlo;
    logic dz;
    int lat;
    int k;
    int busy_low;
    int pulses;
    bit got;
    nhi = m_hi;
    nlo = m_lo;
    dz  = 1'b0;
    lat = 1;
    case (f)
      C_AND:  r = a & b;
      C_OR:   r = a | b;
      C_ADD:  r = a + b;
      C_SUB:  r = a - b;
      C_SLT:  r = ($signed(a) < $signed(b)) ? 1 : 0;
      C_SLL:  r = a << sh;
      C_MFHI: r = m_hi;
      C_MFLO: r = m_lo;
      C_DIVU: begin
        if (b == 0) begin
          nlo = '1;
          nhi = a;
          dz  = DZEN;
          lat = DZEN ? 1 : W + 1;
        end else begin
          nlo = a / b;
          nhi = a % b;
          lat = W + 1;
        end
        r = nhi;
      end
      default: r = '0;
    endcase
    @(negedge clk);
    start = 1'b1;
    funct = f;
    dataA = a;
    dataB = b;
    shamt = sh;
    @(posedge clk);
    #1;
    chk("busy_after_accept", W'(busy), W'(1));
    k = 0;
    busy_low = 0;
    pulses = 0;
    got = 1'b0;
    while (!got && k < 100) begin
      @(negedge clk);
      if (spam && k < 30) begin
        start = 1'(($urandom % 2));
        funct = ops[$urandom % 10];
        dataA = $urandom;
        dataB = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      k++;
      if (done) begin
        got = 1'b1;
        pulses++;
      end else if (!busy) begin
        busy_low++;
      end
    end
    start = 1'b0;
    chk("latency", W'(k), W'(lat));
    chk("busy_held", W'(busy_low), W'(0));
    chk("dataOut", dataOut, r);
    chk("hi", hi, nhi);
    chk("lo", lo, nlo);
    chk("div_zero", W'(div_zero), W'(dz));
    @(negedge clk);
    start = 1'b1;
    funct = C_ADD;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (done) pulses++;
    chk("single_done", W'(pulses), W'(1));
    chk("idle_after_done", W'(busy), W'(0));
    chk("dataOut_held", dataOut, r);
    m_hi = nhi;
    m_lo = nlo;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    funct = '0;
    dataA = '0;
    dataB = '0;
    shamt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_dataOut", dataOut, '0);
    chk("rst_hi", hi, '0);
    chk("rst_lo", lo, '0);
    chk("rst_div_zero", W'(div_zero), W'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run_op(C_ADD, 5, 7, 0, 1'b0);
    run_op(C_SLT, 32'hffffffff, 1, 0, 1'b0);
    run_op(C_SUB, 0, 1, 0, 1'b0);
    run_op(C_DIVU, 100, 7, 0, 1'b0);
    run_op(C_MFLO, 0, 0, 0, 1'b0);
    run_op(C_MFHI, 0, 0, 0, 1'b0);
    run_op(C_DIVU, 1000, 3, 0, 1'b1);
    run_op(C_SLL, 32'h8000_0001, 0, 31, 1'b0);
    run_op(C_DIVU, 9, 0, 0, 1'b0);
    run_op(C_MFHI, 0, 0, 0, 1'b0);

    // abort a division part-way through
    @(negedge clk);
    start = 1'b1;
    funct = C_DIVU;
    dataA = 32'h1234_5678;
    dataB = 3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_done", W'(done), W'(0));
    chk("abort_dataOut", dataOut, '0);
    chk("abort_hi", hi, '0);
    chk("abort_lo", lo, '0);
    chk("abort_div_zero", W'(div_zero), W'(0));
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(C_ADD, 32'hffff_fff0, 32'h20, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [5:0] f;
      logic [W-1:0] a;
      logic [W-1:0] b;
      f = ops[$urandom % 10];
      a = $urandom;
      b = $urandom;
      if (f == C_DIVU) begin
        case ($urandom % 3)
          0: b = 0;
          1: b = $urandom % 17;
          default: ;
        endcase
      end
      run_op(f, a, b, 5'($urandom), 1'(($urandom % 4) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
